// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions: ALU operation encodings, the EX control bundle and
// a saturating counter helper used by the ID/EX pipeline register.
package id_ex_stage_pkg;

  localparam logic [3:0] ALUOP_ADD   = 4'd0;
  localparam logic [3:0] ALUOP_SUB   = 4'd1;
  localparam logic [3:0] ALUOP_AND   = 4'd2;
  localparam logic [3:0] ALUOP_OR    = 4'd3;
  localparam logic [3:0] ALUOP_XOR   = 4'd4;
  localparam logic [3:0] ALUOP_NOR   = 4'd5;
  localparam logic [3:0] ALUOP_SLT   = 4'd6;
  localparam logic [3:0] ALUOP_SLTU  = 4'd7;
  localparam logic [3:0] ALUOP_SLL   = 4'd8;
  localparam logic [3:0] ALUOP_SRL   = 4'd9;
  localparam logic [3:0] ALUOP_SRA   = 4'd10;
  localparam logic [3:0] ALUOP_LUI   = 4'd11;
  localparam logic [3:0] ALUOP_FUNCT = 4'd15;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detect and writeback bypass selects; purely combinational.
// Flush masks the stall so a killed slot never holds the front end.
module hazard_unit
  import id_ex_stage_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       flush_i,
  input  logic       wb_reg_write_i,
  input  logic [4:0] wb_writereg_i,
  output logic       stall_o,
  output logic       fwd_a_o,
  output logic       fwd_b_o
);

  logic load_use;

  // Register 0 is hardwired, so it never creates a dependency.
  assign load_use = ex_valid_i && ex_mem_read_i && (ex_rt_i != 5'd0) && id_valid_i &&
                    ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

  assign stall_o = load_use && !flush_i;

  assign fwd_a_o = wb_reg_write_i && (wb_writereg_i != 5'd0) && (wb_writereg_i == id_rs_i);
  assign fwd_b_o = wb_reg_write_i && (wb_writereg_i != 5'd0) && (wb_writereg_i == id_rt_i);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-cycle latency, inserts a bubble on load-use
// stall or flush, bypasses writeback data and counts stall bubbles (saturating).
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_data1,
  input  logic [31:0] id_data2,
  input  logic        id_regWrite,
  input  logic        id_memRead,
  input  logic        id_memWrite,
  input  logic        id_memToReg,
  input  logic        id_aluSrc,
  input  logic        id_regDst,
  input  logic [3:0]  id_aluOp,
  input  logic        wb_regWrite,
  input  logic [4:0]  wb_writereg,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_writereg,
  output logic        ex_regWrite,
  output logic        ex_memRead,
  output logic        ex_memWrite,
  output logic        ex_memToReg,
  output logic        ex_aluSrc,
  output logic [3:0]  ex_aluOp,
  output logic [15:0] stall_count
);

  logic        ex_valid_q, ex_valid_d;
  ctrl_t       ex_ctrl_q, ex_ctrl_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic [31:0] ex_a_q, ex_a_d;
  logic [31:0] ex_b_q, ex_b_d;
  logic [31:0] ex_imm_q, ex_imm_d;
  logic [4:0]  ex_rs_q, ex_rs_d;
  logic [4:0]  ex_rt_q, ex_rt_d;
  logic [4:0]  ex_writereg_q, ex_writereg_d;
  logic [15:0] stall_count_q, stall_count_d;

  ctrl_t id_ctrl;
  logic  fwd_a, fwd_b, bubble;

  hazard_unit u_hazard (
    .ex_valid_i     (ex_valid_q),
    .ex_mem_read_i  (ex_ctrl_q.mem_read),
    .ex_rt_i        (ex_rt_q),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .flush_i        (flush),
    .wb_reg_write_i (wb_regWrite),
    .wb_writereg_i  (wb_writereg),
    .stall_o        (stall),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b)
  );

  assign id_ctrl = '{reg_write:  id_regWrite,
                     mem_read:   id_memRead,
                     mem_write:  id_memWrite,
                     mem_to_reg: id_memToReg,
                     alu_src:    id_aluSrc,
                     alu_op:     id_aluOp};

  assign bubble = flush || stall;

  always_comb begin
    ex_valid_d    = 1'b0;
    ex_ctrl_d     = ctrl_t'({CTRL_W{1'b0}});
    ex_pc_d       = 32'd0;
    ex_a_d        = 32'd0;
    ex_b_d        = 32'd0;
    ex_imm_d      = 32'd0;
    ex_rs_d       = 5'd0;
    ex_rt_d       = 5'd0;
    ex_writereg_d = 5'd0;
    if (!bubble) begin
      ex_valid_d    = id_valid;
      ex_ctrl_d     = id_valid ? id_ctrl : ctrl_t'({CTRL_W{1'b0}});
      ex_pc_d       = id_pc;
      ex_a_d        = fwd_a ? wb_data : id_data1;
      ex_b_d        = fwd_b ? wb_data : id_data2;
      ex_imm_d      = id_imm;
      ex_rs_d       = id_rs;
      ex_rt_d       = id_rt;
      ex_writereg_d = id_regDst ? id_rd : id_rt;
    end
  end

  // stall already excludes flush cycles, so only real load-use bubbles count.
  assign stall_count_d = stall ? sat_inc16(stall_count_q) : stall_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= ctrl_t'({CTRL_W{1'b0}});
      ex_pc_q       <= 32'd0;
      ex_a_q        <= 32'd0;
      ex_b_q        <= 32'd0;
      ex_imm_q      <= 32'd0;
      ex_rs_q       <= 5'd0;
      ex_rt_q       <= 5'd0;
      ex_writereg_q <= 5'd0;
      stall_count_q <= 16'd0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_pc_q       <= ex_pc_d;
      ex_a_q        <= ex_a_d;
      ex_b_q        <= ex_b_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_writereg_q <= ex_writereg_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_a        = ex_a_q;
  assign ex_b        = ex_b_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign ex_writereg = ex_writereg_q;
  assign ex_regWrite = ex_ctrl_q.reg_write;
  assign ex_memRead  = ex_ctrl_q.mem_read;
  assign ex_memWrite = ex_ctrl_q.mem_write;
  assign ex_memToReg = ex_ctrl_q.mem_to_reg;
  assign ex_aluSrc   = ex_ctrl_q.alu_src;
  assign ex_aluOp    = ex_ctrl_q.alu_op;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, bypass, load-use stall,
// flush, register-0 exclusion, reset mid-stall and counter saturation.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_imm, id_data1, id_data2;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_regDst;
  logic [3:0]  id_aluOp;
  logic        wb_regWrite;
  logic [4:0]  wb_writereg;
  logic [31:0] wb_data;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_writereg;
  logic        ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc;
  logic [3:0]  ex_aluOp;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_imm(id_imm), .id_data1(id_data1), .id_data2(id_data2),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
    .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc), .id_regDst(id_regDst), .id_aluOp(id_aluOp),
    .wb_regWrite(wb_regWrite), .wb_writereg(wb_writereg), .wb_data(wb_data),
    .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_writereg(ex_writereg),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_memToReg(ex_memToReg), .ex_aluSrc(ex_aluSrc), .ex_aluOp(ex_aluOp),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_pc = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_imm = 0;
    id_data1 = 0; id_data2 = 0; id_regWrite = 0; id_memRead = 0; id_memWrite = 0;
    id_memToReg = 0; id_aluSrc = 0; id_regDst = 0; id_aluOp = 0;
    wb_regWrite = 0; wb_writereg = 0; wb_data = 0; flush = 0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  // lw $rt, 0($29): loads into EX on the next edge.
  task automatic load_lw(input logic [4:0] rt);
    clear_inputs();
    id_valid = 1; id_rs = 5'd29; id_rt = rt; id_memRead = 1; id_regWrite = 1;
    id_memToReg = 1; id_aluSrc = 1; id_aluOp = ALUOP_ADD;
    step();
  endtask

  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    clear_inputs();
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_regWrite = 1; id_regDst = 1;
    id_aluOp = ALUOP_ADD; id_pc = 32'h0000_0200;
  endtask

  task automatic test_reset();
    clear_inputs();
    id_valid = 1; id_pc = 32'h1234_5678; id_memRead = 1; id_regWrite = 1; id_rt = 5'd4;
    reset = 1;
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
    checks++; if (ex_pc !== 32'd0) begin errors++; $display("FAIL reset_ex_pc: got %h want 0", ex_pc); end
    checks++; if (ex_regWrite !== 1'b0 || ex_memRead !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got %b%b want 00", ex_regWrite, ex_memRead); end
    checks++; if (ex_rt !== 5'd0 || ex_writereg !== 5'd0) begin errors++; $display("FAIL reset_regs: got rt=%0d wr=%0d want 0", ex_rt, ex_writereg); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %h want 0", stall_count); end
    reset = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
  endtask

  task automatic test_passthrough();
    reset_dut();
    id_valid = 1; id_pc = 32'h0000_0400; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
    id_imm = 32'hFFFF_FFF0; id_data1 = 32'h1111_1111; id_data2 = 32'h2222_2222;
    id_regWrite = 1; id_aluSrc = 1; id_memWrite = 1; id_aluOp = ALUOP_SUB; id_regDst = 1;
    step();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL pass_valid: got %b want 1", ex_valid); end
    checks++; if (ex_pc !== 32'h0000_0400) begin errors++; $display("FAIL pass_pc: got %h want 00000400", ex_pc); end
    checks++; if (ex_a !== 32'h1111_1111 || ex_b !== 32'h2222_2222) begin errors++; $display("FAIL pass_ab: got %h %h want 11111111 22222222", ex_a, ex_b); end
    checks++; if (ex_imm !== 32'hFFFF_FFF0) begin errors++; $display("FAIL pass_imm: got %h want fffffff0", ex_imm); end
    checks++; if (ex_rs !== 5'd1 || ex_rt !== 5'd2) begin errors++; $display("FAIL pass_rsrt: got %0d %0d want 1 2", ex_rs, ex_rt); end
    checks++; if ({ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc} !== 5'b10101) begin
      errors++; $display("FAIL pass_ctrl: got %b%b%b%b%b want 10101", ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc); end
    checks++; if (ex_aluOp !== ALUOP_SUB) begin errors++; $display("FAIL pass_aluop: got %h want %h", ex_aluOp, ALUOP_SUB); end
  endtask

  task automatic test_regdst();
    clear_inputs();
    id_valid = 1; id_regDst = 1; id_rd = 5'd3; id_rt = 5'd7;
    step();
    checks++; if (ex_writereg !== 5'd3) begin errors++; $display("FAIL regdst1: got %0d want 3", ex_writereg); end
    id_regDst = 0;
    step();
    checks++; if (ex_writereg !== 5'd7) begin errors++; $display("FAIL regdst0: got %0d want 7", ex_writereg); end
  endtask

  task automatic test_invalid_gating();
    clear_inputs();
    id_valid = 0; id_pc = 32'h0000_0ABC; id_regWrite = 1; id_memRead = 1; id_memWrite = 1;
    id_memToReg = 1; id_aluSrc = 1; id_aluOp = ALUOP_SLT;
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL inv_valid: got %b want 0", ex_valid); end
    checks++; if ({ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_aluOp} !== 9'd0) begin
      errors++; $display("FAIL inv_ctrl: got %b%b%b%b%b op=%h want all 0", ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_aluOp); end
    checks++; if (ex_pc !== 32'h0000_0ABC) begin errors++; $display("FAIL inv_pc: got %h want 00000abc", ex_pc); end
  endtask

  task automatic test_bypass();
    clear_inputs();
    id_valid = 1; wb_regWrite = 1; wb_writereg = 5'd5; wb_data = 32'hDEAD_BEEF;
    id_rs = 5'd5; id_data1 = 32'd0; id_rt = 5'd6; id_data2 = 32'h0000_0066;
    step();
    checks++; if (ex_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL byp_a: got %h want deadbeef", ex_a); end
    checks++; if (ex_b !== 32'h0000_0066) begin errors++; $display("FAIL byp_b_nomatch: got %h want 00000066", ex_b); end
    id_rs = 5'd6; id_data1 = 32'h0000_0011; id_rt = 5'd5; id_data2 = 32'h0000_0022;
    step();
    checks++; if (ex_b !== 32'hDEAD_BEEF || ex_a !== 32'h0000_0011) begin errors++; $display("FAIL byp_b: got a=%h b=%h want 00000011 deadbeef", ex_a, ex_b); end
    wb_writereg = 5'd0; id_rs = 5'd0; id_data1 = 32'h0000_1234; id_rt = 5'd5; id_data2 = 32'h0000_5678;
    step();
    checks++; if (ex_a !== 32'h0000_1234 || ex_b !== 32'h0000_5678) begin errors++; $display("FAIL byp_r0: got a=%h b=%h want 00001234 00005678", ex_a, ex_b); end
    wb_writereg = 5'd5; wb_regWrite = 0; id_rs = 5'd5; id_data1 = 32'h0000_0ACE;
    step();
    checks++; if (ex_a !== 32'h0000_0ACE) begin errors++; $display("FAIL byp_nowrite: got %h want 00000ace", ex_a); end
  endtask

  task automatic test_load_use();
    reset_dut();
    load_lw(5'd8);
    checks++; if (ex_memRead !== 1'b1 || ex_rt !== 5'd8) begin errors++; $display("FAIL lu_lw_in_ex: got mr=%b rt=%0d want 1 8", ex_memRead, ex_rt); end
    drive_add(5'd8, 5'd9, 5'd10);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall); end
    step();
    checks++; if (ex_valid !== 1'b0 || ex_regWrite !== 1'b0) begin errors++; $display("FAIL lu_bubble: got v=%b rw=%b want 0 0", ex_valid, ex_regWrite); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d want 1", stall_count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once: got %b want 0", stall); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_rs !== 5'd8 || ex_writereg !== 5'd10) begin
      errors++; $display("FAIL lu_add_enters: got v=%b rs=%0d wr=%0d want 1 8 10", ex_valid, ex_rs, ex_writereg); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count_hold: got %0d want 1", stall_count); end
  endtask

  task automatic test_flush();
    reset_dut();
    load_lw(5'd8);
    drive_add(5'd8, 5'd9, 5'd10);
    flush = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b want 0", stall); end
    step();
    checks++; if (ex_valid !== 1'b0 || ex_regWrite !== 1'b0) begin errors++; $display("FAIL fl_bubble: got v=%b rw=%b want 0 0", ex_valid, ex_regWrite); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL fl_count: got %0d want 0", stall_count); end
    flush = 0;
  endtask

  task automatic test_zero_reg();
    reset_dut();
    load_lw(5'd0);
    drive_add(5'd0, 5'd0, 5'd11);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zr_stall: got %b want 0", stall); end
    step();
    checks++; if (ex_valid !== 1'b1 || stall_count !== 16'd0) begin errors++; $display("FAIL zr_pass: got v=%b cnt=%0d want 1 0", ex_valid, stall_count); end
  endtask

  task automatic test_reset_mid_stall();
    reset_dut();
    load_lw(5'd8);
    clear_inputs();
    id_valid = 1; id_rs = 5'd8; id_rt = 5'd8; id_memRead = 1; id_regWrite = 1;
    step();
    step();
    #1;
    checks++; if (stall !== 1'b1 || stall_count !== 16'd1) begin errors++; $display("FAIL rms_setup: got st=%b cnt=%0d want 1 1", stall, stall_count); end
    reset = 1;
    step();
    checks++; if (ex_valid !== 1'b0 || ex_memRead !== 1'b0 || ex_rt !== 5'd0 || ex_a !== 32'd0) begin
      errors++; $display("FAIL rms_outputs: got v=%b mr=%b rt=%0d a=%h want all 0", ex_valid, ex_memRead, ex_rt, ex_a); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rms_count: got %0d want 0", stall_count); end
    reset = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_stall: got %b want 0", stall); end
  endtask

  // Counter preloaded near the top so saturation is reached in a few load-use pairs.
  task automatic test_saturation();
    logic [16:0] expect_cnt;
    reset_dut();
    force dut.stall_count_q = 16'hFFFC;
    step();
    release dut.stall_count_q;
    #1;
    checks++; if (stall_count !== 16'hFFFC) begin errors++; $display("FAIL sat_preload: got %h want fffc", stall_count); end
    clear_inputs();
    id_valid = 1; id_rs = 5'd8; id_rt = 5'd8; id_memRead = 1; id_regWrite = 1;
    step();
    expect_cnt = 17'h0FFFC;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall%0d: got %b want 1", k, stall); end
      step();
      expect_cnt = (expect_cnt == 17'h0FFFF) ? expect_cnt : expect_cnt + 17'd1;
      checks++; if (stall_count !== expect_cnt[15:0]) begin errors++; $display("FAIL sat_count%0d: got %h want %h", k, stall_count, expect_cnt[15:0]); end
      step();
    end
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    test_reset();
    test_passthrough();
    test_regdst();
    test_invalid_gating();
    test_bypass();
    test_load_use();
    test_flush();
    test_zero_reg();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
